// File: rtl/biu_xfer.sv
// Bus-interface transfer engine: moves a register-file word (read then write)
// or writes an immediate, over a shared tristate data bus with a bounded wait.
module biu_xfer #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int IRW     = 32,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic [1:0]     sel,
    input  logic [IRW-1:0] ir,
    inout  wire  [DW-1:0]  data,
    output logic           ready,
    output logic           done,
    output logic           err,
    output logic           gpr_cs,
    output logic           gpr_read,
    output logic [AW-1:0]  gpr_addr,
    input  logic           gpr_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        RD_REQ,
        WR_REQ,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] mbr;

    // Only selected fields of the instruction word are decoded.
    logic unused_ir;
    assign unused_ir = ^ir;

    // The bus is released whenever the state is not WR_REQ, so reset floats it at once.
    assign data = (state == WR_REQ) ? mbr : {DW{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            mbr      <= '0;
        end else begin
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if ((state == RD_REQ || state == WR_REQ) && !gpr_ready
                         && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == DECODE) begin
                src_q <= ir[13 +: AW];
                dst_q <= ir[16 +: AW];
                if (sel == 2'b01) begin
                    mbr <= ir[DW-1:0];
                end
            end
            if (state == RD_REQ && gpr_ready) begin
                mbr <= data;
            end
        end
    end

    // A completing handshake wins over an expiring wait in the same cycle.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        gpr_cs    = 1'b0;
        gpr_read  = 1'b1;
        gpr_addr  = '0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (cs) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (sel[1]) begin
                    state_nxt = ERR;
                end else if (sel[0]) begin
                    state_nxt = WR_REQ;
                end else if (ir[19]) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                gpr_cs   = 1'b1;
                gpr_addr = src_q;
                if (gpr_ready) begin
                    state_nxt = WR_REQ;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ERR;
                end
            end
            WR_REQ: begin
                gpr_cs   = 1'b1;
                gpr_read = 1'b0;
                gpr_addr = dst_q;
                if (gpr_ready) begin
                    state_nxt = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
